// File: rtl/hamming_frame_counter_pkg.sv
// Shared constants and helpers for the serial Hamming encode/decode path.
// Parity positions are one-based powers of two; is_pow2 is reused by the encoder and decoder.
package hamming_pkg;

    localparam int   SHORT_LEN_DEF = 7;
    localparam int   LONG_LEN_DEF  = 15;
    localparam logic MODE_SHORT    = 1'b0;
    localparam logic MODE_LONG     = 1'b1;

    function automatic logic is_pow2(input logic [31:0] position);
        return (position != 32'd0) && ((position & (position - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/hamming_frame_counter_if.sv
// Frame-done request bus toward the codeword store.
// The master raises write and presents the frame count; the store answers with out_ready.
interface hamming_frame_counter_if #(
    parameter int FCNT_W = 16
);
    logic              write;
    logic              out_ready;
    logic [FCNT_W-1:0] frame_cnt;

    modport master (output write, output frame_cnt, input out_ready);
    modport slave  (input write, input frame_cnt, output out_ready);
endinterface

// File: rtl/hamming_frame_counter_req_hold.sv
// Holds the frame-done request until the store accepts it.
// Also tracks a sticky overrun for frames that complete while a request is still pending.
module hamming_req_hold (
    input  logic clk,
    input  logic reset,
    input  logic i_set,
    input  logic i_ready,
    input  logic i_clrErr,
    output logic o_write,
    output logic o_overrun
);

    logic r_write;
    logic r_overrun;
    logic w_overrunEvent;

    // A completion that lands on an unaccepted request merges into it and counts as an overrun.
    assign w_overrunEvent = i_set && r_write && !i_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_write   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (i_set) begin
                r_write <= 1'b1;
            end else if (r_write && i_ready) begin
                r_write <= 1'b0;
            end

            if (w_overrunEvent) begin
                r_overrun <= 1'b1;
            end else if (i_clrErr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_write   = r_write;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/hamming_frame_counter.sv
// Bit-position sequencer for one serial Hamming codeword with a selectable length per frame.
// Reports the current bit index, parity positions, completed frames and a held write request.
module hamming_frame_counter
    import hamming_pkg::*;
#(
    parameter int SHORT_LEN = SHORT_LEN_DEF,
    parameter int LONG_LEN  = LONG_LEN_DEF,
    parameter int CNT_W     = 4,
    parameter int FCNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_en,
    input  logic                 i_mode,
    input  logic                 i_clrErr,
    hamming_frame_counter_if.master bus,
    output logic [CNT_W-1:0]     o_bitIdx,
    output logic                 o_isParity,
    output logic                 o_frameLenLong,
    output logic                 o_overrun
);

    localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(SHORT_LEN - 1);
    localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_LEN - 1);

    logic [CNT_W-1:0]  r_bitIdx;
    logic              r_frameLenLong;
    logic [FCNT_W-1:0] r_frameCnt;
    logic              w_frameLong;
    logic [CNT_W-1:0]  w_lastIdx;
    logic              w_lastBit;
    logic              w_write;

    // On the first bit the live mode decides the length, since the latch updates only at this edge.
    assign w_frameLong = (r_bitIdx == '0) ? i_mode : r_frameLenLong;
    assign w_lastIdx   = (w_frameLong == MODE_LONG) ? LONG_LAST : SHORT_LAST;
    assign w_lastBit   = i_en && (r_bitIdx == w_lastIdx);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bitIdx       <= '0;
            r_frameLenLong <= MODE_SHORT;
            r_frameCnt     <= '0;
        end else if (i_en) begin
            if (r_bitIdx == '0) begin
                r_frameLenLong <= i_mode;
            end
            if (w_lastBit) begin
                r_bitIdx   <= '0;
                r_frameCnt <= r_frameCnt + 1'b1;
            end else begin
                r_bitIdx <= r_bitIdx + 1'b1;
            end
        end
    end

    hamming_req_hold u_reqHold (
        .clk       (clk),
        .reset     (reset),
        .i_set     (w_lastBit),
        .i_ready   (bus.out_ready),
        .i_clrErr  (i_clrErr),
        .o_write   (w_write),
        .o_overrun (o_overrun)
    );

    assign bus.write      = w_write;
    assign bus.frame_cnt  = r_frameCnt;
    assign o_bitIdx       = r_bitIdx;
    assign o_isParity     = is_pow2(32'(r_bitIdx) + 32'd1);
    assign o_frameLenLong = r_frameLenLong;

endmodule

// File: doc/hamming_frame_counter.md
Name: hamming_frame_counter

Overview:
Parametrised bit-position sequencer for the serial Hamming encoder path. It counts enabled serial-bit cycles across one codeword. The codeword length is selectable per frame: short (default 7, i.e. (7,4)) or long (default 15, i.e. (15,11)). At each frame boundary it raises a held write request with a valid/ready handshake toward the codeword store. It also provides the current bit index, a parity-position flag, a frame counter and a sticky overrun error.

Parameters:
SHORT_LEN, 7, codeword length when mode=0; range 3..LONG_LEN.
LONG_LEN, 15, codeword length when mode=1; must satisfy 2^CNT_W >= LONG_LEN.
CNT_W, 4, width of bit_idx.
FCNT_W, 16, width of frame_cnt.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
en  in  1  one serial bit processed this cycle; advances bit_idx
mode  in  1  length select, 0=SHORT_LEN, 1=LONG_LEN; sampled only at the first bit of a frame
out_ready  in  1  store accepts the frame-done request this cycle
clr_err  in  1  clears overrun
bit_idx  out  CNT_W  zero-based position of the bit consumed on the next en cycle
is_parity  out  1  combinational; high when (bit_idx+1) is a power of two (positions 1,2,4,8,...)
frame_len_long  out  1  latched mode of the current frame
write  out  1  frame-complete request; held until accepted
frame_cnt  out  FCNT_W  number of completed frames; wraps modulo 2^FCNT_W
overrun  out  1  sticky; a frame completed while the previous request was still unaccepted

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high, port name reset. All state updates on the rising edge of clk.
- Reset values: bit_idx=0, frame_len_long=0, write=0, frame_cnt=0, overrun=0. Reset takes priority over every other input, including mid-frame and with write pending; the partial frame is discarded.
- Mode latch: frame_len_long <= mode on a cycle with en=1 and bit_idx=0. Mode changes at any other time have no effect on the current frame.
- Length: L = SHORT_LEN if the latched or just-sampled mode=0, else LONG_LEN. At bit_idx=0 the value of mode sampled in that same cycle decides L, which matters only when L=1 and is otherwise irrelevant.
- Counting: when en=1 and bit_idx < L-1, bit_idx <= bit_idx+1. When en=1 and bit_idx = L-1 (last bit), bit_idx <= 0. When en=0, bit_idx holds. There is no stall: counting continues regardless of write.
- Frame done: on the last-bit cycle (en=1, bit_idx=L-1), next cycle write=1 and frame_cnt increments by 1. Latency is 1 cycle from the last en to the write assertion.
- Handshake: write stays 1 until a cycle with write=1 and out_ready=1; it is then 0 next cycle, unless a new frame completes in that same cycle.
- Accept and completion in the same cycle: write stays 1 for the new frame; no overrun.
- Completion while write=1 and out_ready=0: write stays 1 (the two requests merge), overrun <= 1, and frame_cnt still increments.
- overrun clears only on clr_err=1 with no new overrun event in the same cycle; set has priority over clear.
- frame_cnt wraps from 2^FCNT_W-1 to 0 without a flag.
- is_parity is purely combinational from bit_idx and is valid in all cycles.

Decomposition:
- Package hamming_pkg holds:
  - SHORT_LEN_DEF=7, LONG_LEN_DEF=15
  - MODE_SHORT=1'b0, MODE_LONG=1'b1
  - function is_pow2(position) for the parity-position test; the encoder and decoder reuse it.
- One natural sub-module, hamming_req_hold: the write/overrun holding register with accept and set/clear priority.
- The counter and mode latch stay in the top module.

Test Plan:
- reset=1 for 2 cycles with en=1 -> all outputs 0; reset held mid-frame at bit_idx=9 -> bit_idx=0, write=0 next cycle.
- mode=0, out_ready=1, en=1 for 7 cycles -> bit_idx 0..6 then 0; write=1 for exactly 1 cycle after the 7th en; frame_cnt=1; is_parity high at bit_idx 0,1,3.
- mode=1 at the first bit, mode toggled to 0 at bit_idx=5, 15 en cycles -> frame_len_long=1 throughout; write after the 15th en; is_parity high at bit_idx 0,1,3,7.
- en gapped (1,0,0,1,...) over one long frame -> bit_idx holds on en=0; write only after the 15th enabled cycle.
- out_ready=0, two consecutive short frames -> write held high; overrun=1 at the second completion; frame_cnt=2; clr_err=1 -> overrun=0; out_ready=1 -> write=0 next cycle.
- out_ready=1 in the same cycle as the next last-bit en with write pending -> write stays 1, overrun stays 0, frame_cnt increments.
